// File: rtl/ndp_pkg.sv
// rtl/ndp_pkg.sv - shared defaults and FSM state type for the NDP feed scheduler
package ndp_pkg;
  localparam int LAYER_BITS_DEF      = 3;
  localparam int WORDS_PER_LAYER_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/ndp_feed_scheduler_layer_ring_tracker.sv
// rtl/ndp_feed_scheduler_layer_ring_tracker.sv - scratch-pad layer ring: write/read pointers, fill count, word count
module layer_ring_tracker
  import ndp_pkg::*;
#(
  parameter int NUM_LAYERS      = 8,
  parameter int LAYER_BITS      = LAYER_BITS_DEF,
  parameter int WORDS_PER_LAYER = WORDS_PER_LAYER_DEF,
  localparam int WC_BITS        = $clog2(WORDS_PER_LAYER)
) (
  input  logic                  scratch_pad_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LAYER_BITS-1:0] wr_layer,
  input  logic                  wr_allow,
  input  logic                  feed,
  output logic [LAYER_BITS-1:0] rd_ptr,
  output logic [WC_BITS-1:0]    word_cnt,
  output logic                  wr_mismatch,
  output logic                  full,
  output logic                  empty
);
  logic [LAYER_BITS-1:0] wr_ptr;
  logic [LAYER_BITS:0]   count;
  logic [LAYER_BITS:0]   count_next;
  logic                  wr_take;
  logic                  complete;

  assign wr_take     = wr_en && wr_allow && (wr_layer == wr_ptr);
  assign wr_mismatch = wr_en && wr_allow && (wr_layer != wr_ptr);
  assign complete    = wr_take && (word_cnt == WC_BITS'(WORDS_PER_LAYER - 1));

  // A completion and a feed in the same cycle cancel; wr_allow keeps count from exceeding NUM_LAYERS.
  always_comb begin
    count_next = count;
    if (complete && !feed)
      count_next = count + (LAYER_BITS+1)'(1);
    else if (!complete && feed)
      count_next = count - (LAYER_BITS+1)'(1);
  end

  assign full  = (count_next == (LAYER_BITS+1)'(NUM_LAYERS));
  assign empty = (count == '0);

  always_ff @(posedge scratch_pad_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
    end else begin
      if (wr_take) begin
        if (complete) begin
          word_cnt <= '0;
          wr_ptr   <= wr_ptr + LAYER_BITS'(1);
        end else begin
          word_cnt <= word_cnt + WC_BITS'(1);
        end
      end
      if (feed)
        rd_ptr <= rd_ptr + LAYER_BITS'(1);
      count <= count_next;
    end
  end
endmodule

// File: rtl/ndp_feed_scheduler.sv
// rtl/ndp_feed_scheduler.sv - sequences filled scratch-pad layers into the NDP unit
module ndp_feed_scheduler
  import ndp_pkg::*;
#(
  parameter int NUM_LAYERS      = 8,
  parameter int LAYER_BITS      = LAYER_BITS_DEF,
  parameter int WORDS_PER_LAYER = WORDS_PER_LAYER_DEF
) (
  input  logic                  scratch_pad_clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic                  finished_in,
  input  logic                  wr_en,
  input  logic [LAYER_BITS-1:0] wr_layer,
  input  logic                  ndp_calc_done,
  output logic                  HREADY,
  output logic [LAYER_BITS-1:0] layer_addr,
  output logic                  feed_valid,
  output logic                  in_done_flag,
  output logic                  calc_done_flag,
  output logic                  busy,
  output logic                  wr_error
);
  localparam int WC_BITS = $clog2(WORDS_PER_LAYER);

  state_t                state;
  logic                  start_q;
  logic                  start_pulse;
  logic                  finish_latched;
  logic                  wr_allow;
  logic                  feed;
  logic [LAYER_BITS-1:0] rd_ptr;
  logic [WC_BITS-1:0]    word_cnt;
  logic                  wr_mismatch;
  logic                  full;
  logic                  empty;

  assign start_pulse = start_in & ~start_q;
  assign wr_allow    = HREADY && (state != DONE);
  assign feed        = (state == FEED) && !empty;

  layer_ring_tracker #(
    .NUM_LAYERS      (NUM_LAYERS),
    .LAYER_BITS      (LAYER_BITS),
    .WORDS_PER_LAYER (WORDS_PER_LAYER)
  ) u_tracker (
    .scratch_pad_clk (scratch_pad_clk),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_layer        (wr_layer),
    .wr_allow        (wr_allow),
    .feed            (feed),
    .rd_ptr          (rd_ptr),
    .word_cnt        (word_cnt),
    .wr_mismatch     (wr_mismatch),
    .full            (full),
    .empty           (empty)
  );

  always_ff @(posedge scratch_pad_clk) begin
    if (reset) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      finish_latched <= 1'b0;
      HREADY         <= 1'b1;
      layer_addr     <= '0;
      feed_valid     <= 1'b0;
      in_done_flag   <= 1'b0;
      calc_done_flag <= 1'b0;
      busy           <= 1'b0;
      wr_error       <= 1'b0;
    end else begin
      start_q    <= start_in;
      feed_valid <= feed;
      if (feed)
        layer_addr <= rd_ptr;
      // Host writes are dead in DONE, so the port is left open there.
      HREADY <= (state == DONE) || (state == DRAIN && ndp_calc_done) || !full;
      if (wr_mismatch)
        wr_error <= 1'b1;

      case (state)
        IDLE: begin
          finish_latched <= 1'b0;
          if (start_pulse) begin
            state <= FEED;
            busy  <= 1'b1;
          end
        end
        FEED: begin
          if (finished_in)
            finish_latched <= 1'b1;
          // A half-written layer holds us here until the host finishes it.
          if (finish_latched && empty && (word_cnt == '0))
            state <= DRAIN;
        end
        DRAIN: begin
          in_done_flag <= 1'b1;
          if (ndp_calc_done) begin
            state          <= DONE;
            calc_done_flag <= 1'b1;
            busy           <= 1'b0;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ndp_feed_scheduler.sv
// tb/tb_ndp_feed_scheduler.sv - directed self-checking bench for ndp_feed_scheduler
module tb_ndp_feed_scheduler;
  logic       scratch_pad_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_in = 1'b0;
  logic       finished_in = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_layer = 3'd0;
  logic       ndp_calc_done = 1'b0;
  logic       HREADY;
  logic [2:0] layer_addr;
  logic       feed_valid;
  logic       in_done_flag;
  logic       calc_done_flag;
  logic       busy;
  logic       wr_error;

  int checks = 0;
  int errors = 0;

  logic [2:0] fed_q[$];
  int         max_cnt = 0;
  logic       mon_en = 1'b0;

  always #5 scratch_pad_clk = ~scratch_pad_clk;

  ndp_feed_scheduler dut (
    .scratch_pad_clk (scratch_pad_clk),
    .reset           (reset),
    .start_in        (start_in),
    .finished_in     (finished_in),
    .wr_en           (wr_en),
    .wr_layer        (wr_layer),
    .ndp_calc_done   (ndp_calc_done),
    .HREADY          (HREADY),
    .layer_addr      (layer_addr),
    .feed_valid      (feed_valid),
    .in_done_flag    (in_done_flag),
    .calc_done_flag  (calc_done_flag),
    .busy            (busy),
    .wr_error        (wr_error)
  );

  always @(negedge scratch_pad_clk) begin
    if (mon_en) begin
      if (feed_valid)
        fed_q.push_back(layer_addr);
      if (int'(dut.u_tracker.count) > max_cnt)
        max_cnt = int'(dut.u_tracker.count);
    end
  end

  task automatic tick();
    @(posedge scratch_pad_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_in = 1'b0;
    finished_in = 1'b0;
    wr_en = 1'b0;
    ndp_calc_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_words(input int layer, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_layer = 3'(layer);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    chk("rst_hready", HREADY, 1);
    chk("rst_feed_valid", feed_valid, 0);
    chk("rst_layer_addr", layer_addr, 0);
    chk("rst_in_done", in_done_flag, 0);
    chk("rst_calc_done", calc_done_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_error", wr_error, 0);

    // Wrong layer
    write_words(5, 1);
    chk("wrong_layer_err", wr_error, 1);
    chk("wrong_layer_wcnt", dut.u_tracker.word_cnt, 0);
    write_words(0, 1);
    chk("right_layer_wcnt", dut.u_tracker.word_cnt, 1);
    chk("wr_error_sticky", wr_error, 1);

    // Single layer
    do_reset();
    start_in = 1'b1;
    tick();
    chk("single_busy", busy, 1);
    ndp_calc_done = 1'b1;
    tick();
    ndp_calc_done = 1'b0;
    chk("calc_done_ignored_feed", calc_done_flag, 0);
    finished_in = 1'b1;
    write_words(0, 128);
    chk("single_no_feed_yet", feed_valid, 0);
    tick();
    chk("single_feed", feed_valid, 1);
    chk("single_addr", layer_addr, 0);
    tick();
    chk("single_feed_once", feed_valid, 0);
    chk("single_in_done_early", in_done_flag, 0);
    tick();
    chk("single_in_done", in_done_flag, 1);
    chk("single_busy_drain", busy, 1);
    chk("single_calc_not_yet", calc_done_flag, 0);
    ndp_calc_done = 1'b1;
    tick();
    ndp_calc_done = 1'b0;
    chk("single_calc_done", calc_done_flag, 1);
    chk("single_busy_done", busy, 0);
    write_words(1, 1);
    chk("done_calc_held", calc_done_flag, 1);
    chk("done_in_done_held", in_done_flag, 1);
    chk("done_hready", HREADY, 1);
    chk("done_write_ignored", dut.u_tracker.word_cnt, 0);
    chk("done_no_error", wr_error, 0);

    // Full / backpressure
    do_reset();
    for (int l = 0; l < 8; l++) begin
      write_words(l, 128);
      if (l == 6)
        chk("bp_hready_7", HREADY, 1);
    end
    chk("bp_hready_8", HREADY, 0);
    write_words(0, 1);
    chk("bp_9th_ignored", dut.u_tracker.word_cnt, 0);
    chk("bp_9th_no_err", wr_error, 0);
    start_in = 1'b1;
    tick();
    chk("bp_start_no_feed", feed_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_feed_valid", feed_valid, 1);
      chk("bp_feed_addr", layer_addr, 32'(i));
      if (i == 0)
        chk("bp_hready_back", HREADY, 1);
    end
    tick();
    chk("bp_feed_end", feed_valid, 0);

    // Wrap-around
    do_reset();
    start_in = 1'b1;
    tick();
    fed_q.delete();
    max_cnt = 0;
    mon_en = 1'b1;
    for (int l = 0; l < 20; l++)
      write_words(l % 8, 128);
    repeat (4) tick();
    mon_en = 1'b0;
    chk("wrap_count", fed_q.size(), 20);
    for (int i = 0; i < 20; i++)
      chk("wrap_addr", (i < fed_q.size()) ? 32'(fed_q[i]) : 32'hFFFF_FFFF, 32'(i % 8));
    chk("wrap_max_le8", (max_cnt <= 8), 1);
    chk("wrap_no_err", wr_error, 0);

    // Simultaneous complete + feed
    do_reset();
    write_words(0, 128);
    write_words(1, 127);
    start_in = 1'b1;
    tick();
    chk("sim_no_feed_yet", feed_valid, 0);
    write_words(1, 1);
    chk("sim_feed0", feed_valid, 1);
    chk("sim_addr0", layer_addr, 0);
    chk("sim_count1", dut.u_tracker.count, 1);
    tick();
    chk("sim_feed1", feed_valid, 1);
    chk("sim_addr1", layer_addr, 1);
    chk("sim_count0", dut.u_tracker.count, 0);

    // Reset mid-feed
    do_reset();
    for (int l = 0; l < 4; l++)
      write_words(l, 128);
    start_in = 1'b1;
    tick();
    tick();
    chk("mid_count3", dut.u_tracker.count, 3);
    chk("mid_feeding", feed_valid, 1);
    do_reset();
    chk("mid_rst_hready", HREADY, 1);
    chk("mid_rst_feed", feed_valid, 0);
    chk("mid_rst_addr", layer_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_done", in_done_flag, 0);
    chk("mid_rst_calc", calc_done_flag, 0);
    chk("mid_rst_count", dut.u_tracker.count, 0);
    start_in = 1'b1;
    tick();
    write_words(0, 128);
    tick();
    chk("restart_feed", feed_valid, 1);
    chk("restart_addr", layer_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
